// File: rtl/pipeline_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_pkg
// Shared definitions for the pipeline sequencer and its hazard detector:
//   - NOP_CMD bubble encoding (ALU class, op 1110: no reads, no writes)
//   - instruction class codes and the ALU op codes the sequencer cares about
//   - sequencer state encoding
//   - small decode helpers working on the class [15:14] and op [7:4] fields
// -----------------------------------------------------------------------------
package pipeline_sequencer_pkg;

  localparam logic [15:0] NOP_CMD = 16'hC0E0;

  // Instruction class, bits [15:14]
  localparam logic [1:0] CLS_LD     = 2'b00;
  localparam logic [1:0] CLS_ST     = 2'b01;
  localparam logic [1:0] CLS_IMM_BR = 2'b10;
  localparam logic [1:0] CLS_ALU    = 2'b11;

  // ALU op, bits [7:4]
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_IN  = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Number of NOP shifts after HLT leaves decode before the pipeline is empty
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic logic is_hlt(input logic [1:0] cls, input logic [3:0] op);
    return (cls == CLS_ALU) && (op == OP_HLT);
  endfunction

  // Instruction reads the register named in [13:11]
  function automatic logic uses_rs(input logic [1:0] cls, input logic [3:0] op);
    logic r;
    r = 1'b0;
    if (cls == CLS_ALU) begin
      r = (op <= OP_MOV) || (op == OP_OUT);
    end else if (cls == CLS_ST) begin
      r = 1'b1;
    end
    return r;
  endfunction

  // Instruction reads the register named in [10:8]
  function automatic logic uses_rb(input logic [1:0] cls, input logic [3:0] op);
    logic r;
    r = 1'b0;
    if (cls == CLS_ALU) begin
      // 0000..0101 are two-operand ALU ops, 1000..1011 are shifts
      r = (op <= OP_CMP) || (op[3:2] == 2'b10);
    end else if ((cls == CLS_LD) || (cls == CLS_ST)) begin
      r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_hazard_detect
// Combinational load-use detector. Flags when the instruction one stage older
// than decode is a load whose destination is a source of the instruction now in
// decode, so the sequencer must insert one bubble.
// Ports:
//   cmd_hi_i      in  [15:4]  decode-stage instruction (low nibble not needed)
//   before_hdr_i  in  [4:0]   BeforeCOMMAND[15:11]: class and load destination
//   load_use_o    out 1       load-use hazard present this cycle
// -----------------------------------------------------------------------------
module pipeline_sequencer_hazard_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic [11:0] cmd_hi_i,
  input  logic [4:0]  before_hdr_i,
  output logic        load_use_o
);

  logic [1:0] cmd_cls;
  logic [2:0] cmd_rs;
  logic [2:0] cmd_rb;
  logic [3:0] cmd_op;
  logic [1:0] bef_cls;
  logic [2:0] bef_dst;

  // cmd_hi_i[11:0] carries COMMAND[15:4]
  assign cmd_cls = cmd_hi_i[11:10];
  assign cmd_rs  = cmd_hi_i[9:7];
  assign cmd_rb  = cmd_hi_i[6:4];
  assign cmd_op  = cmd_hi_i[3:0];
  assign bef_cls = before_hdr_i[4:3];
  assign bef_dst = before_hdr_i[2:0];

  always_comb begin
    load_use_o = 1'b0;
    if (bef_cls == CLS_LD) begin
      load_use_o = (uses_rs(cmd_cls, cmd_op) && (cmd_rs == bef_dst)) ||
                   (uses_rb(cmd_cls, cmd_op) && (cmd_rb == bef_dst));
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Holds the three instruction-history registers feeding decode and sequences
// the pipeline: normal shift, load-use bubble, branch flush, external stall,
// and HLT drain/halt.
// Ports:
//   clk               in  1      clock
//   rst               in  1      synchronous active-high reset
//   start             in  1      leave IDLE and begin fetching
//   IMEM_DATA         in  16     instruction at current PC
//   branch_taken      in  1      branch in BeforeCOMMAND resolved taken
//   stall_ext         in  1      memory busy, freeze everything
//   COMMAND           out 16     decode-stage instruction
//   BeforeCOMMAND     out 16     one stage older
//   TwoBeforeCOMMAND  out 16     two stages older
//   pc_enable         out 1      PC may advance/load this cycle
//   bubble            out 1      a NOP is inserted this cycle
//   halted            out 1      pipeline drained after HLT
//   stall_count       out CNT_W  saturating count of lost cycles
// pc_enable and bubble describe the action taken at the coming clock edge,
// so they are combinational from state and this cycle's inputs.
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter logic [15:0] NOP_CMD = pipeline_sequencer_pkg::NOP_CMD,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      IMEM_DATA,
  input  logic             branch_taken,
  input  logic             stall_ext,
  output logic [15:0]      COMMAND,
  output logic [15:0]      BeforeCOMMAND,
  output logic [15:0]      TwoBeforeCOMMAND,
  output logic             pc_enable,
  output logic             bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  import pipeline_sequencer_pkg::*;

  state_t           state_q, state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      bef_q, bef_d;
  logic [15:0]      two_q, two_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       drain_q, drain_d;
  logic             pc_en_d;
  logic             bubble_d;
  logic             load_use;
  logic             cmd_is_hlt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pipeline_sequencer_hazard_detect u_hazard (
    .cmd_hi_i     (cmd_q[15:4]),
    .before_hdr_i (bef_q[15:11]),
    .load_use_o   (load_use)
  );

  assign cmd_is_hlt = is_hlt(cmd_q[15:14], cmd_q[7:4]);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bef_d    = bef_q;
    two_d    = two_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    pc_en_d  = 1'b0;
    bubble_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end

      // STALL lasts one cycle and then acts like RUN; load_use cannot fire
      // there because Before was just replaced by a NOP. A HLT held in
      // COMMAND during the stall is caught here on the following cycle.
      ST_RUN, ST_STALL: begin
        if (branch_taken) begin
          two_d    = bef_q;
          bef_d    = NOP_CMD;
          cmd_d    = NOP_CMD;
          pc_en_d  = 1'b1;
          bubble_d = 1'b1;
          cnt_d    = sat_inc(cnt_q);
          state_d  = ST_RUN;
        end else if (stall_ext) begin
          cnt_d = sat_inc(cnt_q);
        end else if (load_use) begin
          two_d    = bef_q;
          bef_d    = NOP_CMD;
          bubble_d = 1'b1;
          cnt_d    = sat_inc(cnt_q);
          state_d  = ST_STALL;
        end else if (cmd_is_hlt) begin
          two_d   = bef_q;
          bef_d   = cmd_q;
          cmd_d   = NOP_CMD;
          drain_d = DRAIN_CYCLES;
          state_d = ST_DRAIN;
        end else begin
          two_d   = bef_q;
          bef_d   = cmd_q;
          cmd_d   = IMEM_DATA;
          pc_en_d = 1'b1;
          state_d = ST_RUN;
        end
      end

      // HLT is already past decode, so branch_taken is ignored here
      ST_DRAIN: begin
        if (stall_ext) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          two_d   = bef_q;
          bef_d   = cmd_q;
          cmd_d   = NOP_CMD;
          drain_d = drain_q - 2'd1;
          if (drain_q == 2'd1) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_HALT: begin
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= NOP_CMD;
      bef_q   <= NOP_CMD;
      two_q   <= NOP_CMD;
      cnt_q   <= '0;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bef_q   <= bef_d;
      two_q   <= two_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  assign COMMAND          = cmd_q;
  assign BeforeCOMMAND    = bef_q;
  assign TwoBeforeCOMMAND = two_q;
  assign pc_enable        = pc_en_d & ~rst;
  assign bubble           = bubble_d & ~rst;
  assign halted           = (state_q == ST_HALT);
  assign stall_count      = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  localparam logic [15:0] N  = 16'hC0E0;
  localparam logic        L0 = 1'b0;
  localparam logic        L1 = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        branch_taken = 1'b0;
  logic        stall_ext = 1'b0;
  logic [15:0] imem = 16'h0000;

  logic [15:0] cmd, bef, two;
  logic        pc_en, bub, halt;
  logic [15:0] cnt;

  logic [15:0] cmd2, bef2, two2;
  logic        pc_en2, bub2, halt2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .IMEM_DATA(imem),
    .branch_taken(branch_taken), .stall_ext(stall_ext),
    .COMMAND(cmd), .BeforeCOMMAND(bef), .TwoBeforeCOMMAND(two),
    .pc_enable(pc_en), .bubble(bub), .halted(halt), .stall_count(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run
  pipeline_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .IMEM_DATA(imem),
    .branch_taken(branch_taken), .stall_ext(stall_ext),
    .COMMAND(cmd2), .BeforeCOMMAND(bef2), .TwoBeforeCOMMAND(two2),
    .pc_enable(pc_en2), .bubble(bub2), .halted(halt2), .stall_count(cnt2)
  );

  typedef struct {
    logic        r, s, b, x;
    logic [15:0] im;
    logic        pc, bub;
    logic [15:0] cmd, bef, two;
    logic        halt;
    int          cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic x, input logic [15:0] im,
                              input logic pc, input logic bu,
                              input logic [15:0] c, input logic [15:0] be,
                              input logic [15:0] tw, input logic h,
                              input int n);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.x = x; v.im = im;
    v.pc = pc; v.bub = bu; v.cmd = c; v.bef = be; v.two = tw;
    v.halt = h; v.cnt = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs mid-cycle, sample the combinational controls, then clock
  task automatic drive(input logic r, input logic s, input logic b, input logic x,
                       input logic [15:0] im, output logic pc_o, output logic bub_o);
    @(negedge clk);
    rst = r; start = s; branch_taken = b; stall_ext = x; imem = im;
    #1;
    pc_o = pc_en;
    bub_o = bub;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic p, bb;
    int   sat;

    //            r   s   b   x   imem       pc  bub  cmd       bef       two       halt cnt
    tv.push_back(mk(L1, L0, L0, L0, 16'h0000, L0, L0, N,        N,        N,        L0, 0)); // 0 reset
    tv.push_back(mk(L0, L0, L0, L0, 16'hC100, L0, L0, N,        N,        N,        L0, 0)); // 1 idle holds
    tv.push_back(mk(L0, L1, L0, L0, 16'hC100, L0, L0, N,        N,        N,        L0, 0)); // 2 start
    tv.push_back(mk(L0, L0, L0, L0, 16'hC100, L1, L0, 16'hC100, N,        N,        L0, 0)); // 3 first shift
    tv.push_back(mk(L0, L0, L0, L0, 16'hC300, L1, L0, 16'hC300, 16'hC100, N,        L0, 0));
    tv.push_back(mk(L0, L0, L0, L0, 16'hC500, L1, L0, 16'hC500, 16'hC300, 16'hC100, L0, 0));
    tv.push_back(mk(L0, L0, L0, L0, 16'h1000, L1, L0, 16'h1000, 16'hC500, 16'hC300, L0, 0)); // LD r2
    tv.push_back(mk(L0, L0, L0, L0, 16'hC200, L1, L0, 16'hC200, 16'h1000, 16'hC500, L0, 0)); // ADD rb=2
    tv.push_back(mk(L0, L0, L0, L0, 16'hC400, L0, L1, 16'hC200, N,        16'h1000, L0, 1)); // 8 bubble
    tv.push_back(mk(L0, L0, L0, L0, 16'hC400, L1, L0, 16'hC400, 16'hC200, N,        L0, 1)); // 9 resume
    tv.push_back(mk(L0, L0, L0, L0, 16'h1000, L1, L0, 16'h1000, 16'hC400, 16'hC200, L0, 1));
    tv.push_back(mk(L0, L0, L0, L0, 16'hC300, L1, L0, 16'hC300, 16'h1000, 16'hC400, L0, 1)); // ADD rb=3
    tv.push_back(mk(L0, L0, L0, L0, 16'hC600, L1, L0, 16'hC600, 16'hC300, 16'h1000, L0, 1)); // 12 no stall
    tv.push_back(mk(L0, L0, L0, L0, 16'h8123, L1, L0, 16'h8123, 16'hC600, 16'hC300, L0, 1)); // branch
    tv.push_back(mk(L0, L0, L0, L0, 16'hC700, L1, L0, 16'hC700, 16'h8123, 16'hC600, L0, 1));
    tv.push_back(mk(L0, L0, L1, L0, 16'hDEAD, L1, L1, N,        N,        16'h8123, L0, 2)); // 15 flush
    tv.push_back(mk(L0, L0, L0, L0, 16'hC100, L1, L0, 16'hC100, N,        N,        L0, 2));
    tv.push_back(mk(L0, L0, L0, L1, 16'hC200, L0, L0, 16'hC100, N,        N,        L0, 3)); // 17 stall_ext
    tv.push_back(mk(L0, L0, L0, L1, 16'hC200, L0, L0, 16'hC100, N,        N,        L0, 4));
    tv.push_back(mk(L0, L0, L0, L1, 16'hC200, L0, L0, 16'hC100, N,        N,        L0, 5));
    tv.push_back(mk(L0, L0, L0, L0, 16'hC200, L1, L0, 16'hC200, 16'hC100, N,        L0, 5)); // 20 resume
    tv.push_back(mk(L0, L0, L0, L0, 16'hC300, L1, L0, 16'hC300, 16'hC200, 16'hC100, L0, 5));
    tv.push_back(mk(L0, L0, L0, L0, 16'hC0F0, L1, L0, 16'hC0F0, 16'hC300, 16'hC200, L0, 5)); // HLT fetched
    tv.push_back(mk(L0, L0, L0, L0, 16'hC400, L0, L0, N,        16'hC0F0, 16'hC300, L0, 5)); // 23 detect
    tv.push_back(mk(L0, L0, L1, L0, 16'hC500, L0, L0, N,        N,        16'hC0F0, L0, 5)); // 24 drain, br ignored
    tv.push_back(mk(L0, L0, L0, L0, 16'hC600, L0, L0, N,        N,        N,        L1, 5)); // 25 halted
    tv.push_back(mk(L0, L1, L0, L0, 16'hC600, L0, L0, N,        N,        N,        L1, 5)); // 26 halt holds
    tv.push_back(mk(L1, L0, L0, L0, 16'hC600, L0, L0, N,        N,        N,        L0, 0)); // 27 reset exits

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].r; start = tv[i].s; branch_taken = tv[i].b;
      stall_ext = tv[i].x; imem = tv[i].im;
      #1;
      chk($sformatf("row%0d pc_enable", i), {31'd0, pc_en}, {31'd0, tv[i].pc});
      chk($sformatf("row%0d bubble", i), {31'd0, bub}, {31'd0, tv[i].bub});
      chk($sformatf("row%0d sat pc/bubble", i), {30'd0, pc_en2, bub2}, {30'd0, tv[i].pc, tv[i].bub});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d COMMAND", i), {16'd0, cmd}, {16'd0, tv[i].cmd});
      chk($sformatf("row%0d BeforeCOMMAND", i), {16'd0, bef}, {16'd0, tv[i].bef});
      chk($sformatf("row%0d TwoBeforeCOMMAND", i), {16'd0, two}, {16'd0, tv[i].two});
      chk($sformatf("row%0d halted", i), {31'd0, halt}, {31'd0, tv[i].halt});
      chk($sformatf("row%0d stall_count", i), {16'd0, cnt}, tv[i].cnt);
      sat = (tv[i].cnt > 3) ? 3 : tv[i].cnt;
      chk($sformatf("row%0d sat stall_count", i), {30'd0, cnt2}, sat);
      chk($sformatf("row%0d sat regs", i), {cmd2, bef2}, {tv[i].cmd, tv[i].bef});
      chk($sformatf("row%0d sat two/halt", i), {15'd0, two2, halt2}, {15'd0, tv[i].two, tv[i].halt});
    end

    // Reset while in STALL
    drive(L0, L1, L0, L0, N, p, bb);
    drive(L0, L0, L0, L0, 16'h1000, p, bb);
    drive(L0, L0, L0, L0, 16'hC200, p, bb);
    drive(L0, L0, L0, L0, 16'hC400, p, bb);
    chk("stallA bubble", {31'd0, bb}, 32'd1);
    chk("stallA regs", {cmd, bef}, {16'hC200, N});
    chk("stallA count", {16'd0, cnt}, 32'd1);
    drive(L1, L0, L0, L0, 16'hC400, p, bb);
    chk("rstStall regs", {cmd, bef}, {N, N});
    chk("rstStall two/halt", {15'd0, two, halt}, {15'd0, N, 1'b0});
    chk("rstStall count", {16'd0, cnt}, 32'd0);
    drive(L0, L0, L0, L0, 16'hC100, p, bb);
    chk("rstStall idle pc", {31'd0, p}, 32'd0);
    chk("rstStall idle cmd", {16'd0, cmd}, {16'd0, N});

    // Branch taken while in STALL overrides the plain resume shift
    drive(L0, L1, L0, L0, N, p, bb);
    drive(L0, L0, L0, L0, 16'h1000, p, bb);
    drive(L0, L0, L0, L0, 16'hC200, p, bb);
    drive(L0, L0, L0, L0, 16'hC400, p, bb);
    drive(L0, L0, L1, L0, 16'hC700, p, bb);
    chk("brStall pc/bubble", {30'd0, p, bb}, 32'd3);
    chk("brStall regs", {cmd, bef}, {N, N});
    chk("brStall count", {16'd0, cnt}, 32'd2);
    drive(L0, L0, L0, L0, 16'hC700, p, bb);
    chk("brStall resume", {16'd0, cmd}, {16'd0, 16'hC700});

    // Reset while in DRAIN
    drive(L0, L0, L0, L0, 16'hC0F0, p, bb);
    drive(L0, L0, L0, L0, 16'hC500, p, bb);
    chk("drainB pc", {31'd0, p}, 32'd0);
    chk("drainB regs", {cmd, bef}, {N, 16'hC0F0});
    chk("drainB two", {16'd0, two}, {16'd0, 16'hC700});
    drive(L1, L0, L0, L0, 16'hC500, p, bb);
    chk("rstDrain regs", {cmd, bef}, {N, N});
    chk("rstDrain two/halt", {15'd0, two, halt}, {15'd0, N, 1'b0});
    chk("rstDrain count", {16'd0, cnt}, 32'd0);
    drive(L0, L0, L0, L0, 16'hC100, p, bb);
    chk("rstDrain idle", {15'd0, cmd, p}, {15'd0, N, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
